// File: rtl/div_sequencer_pkg.sv
// Shared constants and state encoding for the multicycle signed divider.
package div_sequencer_pkg;

  // Operand, quotient and remainder width.
  localparam int WIDTH = 32;

  // Width of the iteration counter.
  localparam int CW = $clog2(WIDTH) + 1;

  // Counter value on the final subtract/shift step.
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_e;

endpackage

// File: rtl/div_sequencer_twos_negate.sv
// Two's complement negation: the bitwise inverter feeding a +1 incrementer.
module twos_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  // Invert every bit, then add one.
  always_comb begin
    y = ~x + W'(1);
  end

endmodule

// File: rtl/div_sequencer.sv
// Multicycle signed restoring divider: one quotient bit per clock,
// sign correction on entry and exit, fixed latency from start to result.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              sign_q, sign_d;
  logic              zero_div_q, zero_div_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              exc_q, exc_d;
  logic              rdy_q, rdy_d;

  logic [WIDTH-1:0]  neg_a, neg_b, neg_q;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    trial;

  twos_negate #(.W(WIDTH)) u_neg_a (.x(data_operandA), .y(neg_a));
  twos_negate #(.W(WIDTH)) u_neg_b (.x(data_operandB), .y(neg_b));
  twos_negate #(.W(WIDTH)) u_neg_q (.x(q_q),           .y(neg_q));

  // Magnitudes of the operands and the trial subtraction for one step.
  always_comb begin
    abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
    abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;
    trial = {r_q, q_q[WIDTH-1]} - {1'b0, d_q};
  end

  // State register plus all datapath and output flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      q_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      sign_q     <= 1'b0;
      zero_div_q <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      q_q        <= q_d;
      d_q        <= d_d;
      r_q        <= r_d;
      sign_q     <= sign_d;
      zero_div_q <= zero_div_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      rdy_q      <= rdy_d;
    end
  end

  // Next state: a start pulse always wins, otherwise iterate then fix up once.
  always_comb begin
    state_d = state_q;
    if (ctrl_div) begin
      state_d = ITER;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ITER:    state_d = (count_q == LAST_COUNT) ? FIXUP : ITER;
        FIXUP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand capture on start, one restoring subtract/shift step per ITER cycle.
  always_comb begin
    count_d    = count_q;
    q_d        = q_q;
    d_d        = d_q;
    r_d        = r_q;
    sign_d     = sign_q;
    zero_div_d = zero_div_q;
    if (ctrl_div) begin
      q_d        = abs_a;
      d_d        = abs_b;
      r_d        = '0;
      count_d    = '0;
      sign_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      zero_div_d = (data_operandB == '0);
    end else if (state_q == ITER) begin
      if (!trial[WIDTH]) begin
        r_d = trial[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end
      count_d = count_q + CW'(1);
    end
  end

  // Outputs: publish the signed quotient and a one-cycle ready pulse from FIXUP.
  always_comb begin
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (ctrl_div) begin
      exc_d = 1'b0;
    end else if (state_q == FIXUP) begin
      result_d = zero_div_q ? '0 : (sign_q ? neg_q : q_q);
      exc_d    = zero_div_q;
      rdy_d    = 1'b1;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule
